// File: rtl/dma_pkg.sv
// Shared types and widths for the DMA halt arbiter.
package dma_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HALT_WAIT = 3'd1,
    XFER      = 3'd2,
    DRAIN     = 3'd3,
    RELEASE   = 3'd4
  } state_t;

endpackage

// File: rtl/dma_read_pipe.sv
// Tracks outstanding DMA reads and captures each returning byte with its index.
// Bit i of vld_p is set when a read was issued i+1 cycles ago. The top bit
// is the dma_valid strobe. The bit below it marks the read whose data is on
// mem_rdata in the current cycle. For MEM_LAT=1 that read is the one being
// issued now.
module dma_read_pipe
  import dma_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              issue,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pending,
  output logic              dma_valid,
  output logic [DATA_W-1:0] dma_data,
  output logic [7:0]        dma_idx
);

  logic [MEM_LAT-1:0] vld_p;
  logic               arrive;
  logic [7:0]         idx_cnt;

  generate
    if (MEM_LAT == 1) begin : g_lat1
      assign arrive  = issue;
      assign pending = 1'b0;
    end else begin : g_latn
      assign arrive  = vld_p[MEM_LAT-2];
      assign pending = |vld_p[MEM_LAT-2:0];
    end
  endgenerate

  assign dma_valid = vld_p[MEM_LAT-1];

  // Shift the outstanding-read markers one step per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p <= (vld_p << 1) | MEM_LAT'(issue);
    end
  end

  // Capture the arriving byte and number it within the current transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_data <= '0;
      dma_idx  <= '0;
      idx_cnt  <= '0;
    end else if (clear) begin
      idx_cnt <= '0;
    end else if (arrive) begin
      dma_data <= mem_rdata;
      dma_idx  <= idx_cnt;
      idx_cnt  <= idx_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/dma_halt_arbiter.sv
// Halts the 6502 on a DMA request and lets it settle. It then streams
// sequential reads from memory to the consumer and hands the bus back.
module dma_halt_arbiter
  import dma_pkg::*;
#(
  parameter int HALT_SETTLE = 2,
  parameter int MEM_LAT     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_ab,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_do,
  output logic [DATA_W-1:0] cpu_di,
  output logic              halt_b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_base,
  input  logic [7:0]        dma_len,
  output logic              dma_busy,
  output logic              dma_valid,
  output logic [DATA_W-1:0] dma_data,
  output logic [7:0]        dma_idx,
  output logic              dma_done
);

  localparam logic [3:0] SETTLE_INIT = 4'(HALT_SETTLE - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [8:0]        remain_q;
  logic [3:0]        settle_q;
  logic              start;
  logic              issue;
  logic              pending;
  logic              dma_own;

  // Next-state and per-state outputs.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    issue    = 1'b0;
    halt_b   = 1'b1;
    dma_busy = 1'b1;
    dma_done = 1'b0;
    dma_own  = 1'b0;
    case (state)
      IDLE: begin
        dma_busy = 1'b0;
        if (dma_req) begin
          start    = 1'b1;
          state_nx = HALT_WAIT;
        end
      end
      HALT_WAIT: begin
        halt_b = 1'b0;
        if (settle_q == 4'd0) state_nx = XFER;
      end
      XFER: begin
        halt_b  = 1'b0;
        dma_own = 1'b1;
        issue   = 1'b1;
        if (remain_q == 9'd1) state_nx = DRAIN;
      end
      DRAIN: begin
        halt_b  = 1'b0;
        dma_own = 1'b1;
        if (!pending) state_nx = RELEASE;
      end
      RELEASE: begin
        dma_done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Settle countdown and remaining-byte count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_q <= '0;
      remain_q <= '0;
    end else if (start) begin
      settle_q <= SETTLE_INIT;
      remain_q <= (dma_len == 8'd0) ? 9'd256 : {1'b0, dma_len};
    end else begin
      if (state == HALT_WAIT && settle_q != 4'd0) settle_q <= settle_q - 4'd1;
      if (issue && remain_q != 9'd1)              remain_q <= remain_q - 9'd1;
    end
  end

  // DMA address counter. It wraps at 16 bits and holds the last address in DRAIN.
  always_ff @(posedge clk) begin
    if (start)                          addr_q <= dma_base;
    else if (issue && remain_q != 9'd1) addr_q <= addr_q + 16'd1;
  end

  // Bus mux. The DMA side never writes.
  assign mem_addr  = dma_own ? addr_q : cpu_ab;
  assign mem_we    = dma_own ? 1'b0   : cpu_we;
  assign mem_wdata = dma_own ? '0     : cpu_do;
  assign cpu_di    = mem_rdata;

  dma_read_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_read_pipe (
    .clk       (clk),
    .reset     (reset),
    .clear     (start),
    .issue     (issue),
    .mem_rdata (mem_rdata),
    .pending   (pending),
    .dma_valid (dma_valid),
    .dma_data  (dma_data),
    .dma_idx   (dma_idx)
  );

endmodule

// File: tb/tb_dma_halt_arbiter.sv
// Bench for dma_halt_arbiter. A transaction-level model predicts every
// output on every cycle from the request parameters. Directed literal checks
// pin counts, first bytes, last addresses and the reset behaviour.
module tb_dma_halt_arbiter;

  localparam int HS = 2;
  localparam int ML = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_ab = 16'h0000;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_do = 8'h00;
  logic [7:0]  cpu_di;
  logic        halt_b;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        dma_req = 1'b0;
  logic [15:0] dma_base = 16'h0000;
  logic [7:0]  dma_len = 8'h00;
  logic        dma_busy;
  logic        dma_valid;
  logic [7:0]  dma_data;
  logic [7:0]  dma_idx;
  logic        dma_done;

  int n_cmp = 0;
  int n_err = 0;

  dma_halt_arbiter #(.HALT_SETTLE(HS), .MEM_LAT(ML)) dut (
    .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_do(cpu_do),
    .cpu_di(cpu_di), .halt_b(halt_b), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dma_req(dma_req),
    .dma_base(dma_base), .dma_len(dma_len), .dma_busy(dma_busy),
    .dma_valid(dma_valid), .dma_data(dma_data), .dma_idx(dma_idx),
    .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  // Memory returns the low byte of the address (single-cycle latency).
  assign mem_rdata = mem_addr[7:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: cycle k of an accepted request (k=1 is the cycle after the accepting edge).
  bit          m_active = 1'b0;
  int          m_k = 0;
  logic [15:0] m_base = 16'h0;
  int          m_n = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
    end else if (m_active) begin
      if (m_k == HS + m_n + ML + 1) m_active <= 1'b0;
      else                         m_k <= m_k + 1;
    end else if (dma_req) begin
      m_active <= 1'b1;
      m_k      <= 1;
      m_base   <= dma_base;
      m_n      <= (dma_len == 8'd0) ? 256 : int'(dma_len);
    end
  end

  // Compare the DUT to the model on every falling edge.
  always @(negedge clk) begin
    logic        e_halt, e_busy, e_valid, e_done, e_own, e_we;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata, e_data, e_idx;
    int          k;
    e_halt = 1'b1; e_busy = 1'b0; e_valid = 1'b0; e_done = 1'b0; e_own = 1'b0;
    e_addr = cpu_ab; e_we = cpu_we; e_wdata = cpu_do; e_data = 8'h00; e_idx = 8'h00;
    k = m_k;
    if (m_active && !reset) begin
      e_busy = 1'b1;
      if (k <= HS + m_n + ML) e_halt = 1'b0;
      if (k == HS + m_n + ML + 1) e_done = 1'b1;
      if (k > HS && k <= HS + m_n + ML) begin
        e_own   = 1'b1;
        e_addr  = (k <= HS + m_n) ? 16'(m_base + 16'(k - HS - 1)) : 16'(m_base + 16'(m_n - 1));
        e_we    = 1'b0;
        e_wdata = 8'h00;
      end
      if (k >= HS + 1 + ML && k <= HS + m_n + ML) begin
        e_valid = 1'b1;
        e_idx   = 8'(k - HS - 1 - ML);
        e_data  = 8'(m_base + 16'(k - HS - 1 - ML));
      end
    end
    chk("halt_b", 32'(halt_b), 32'(e_halt));
    chk("dma_busy", 32'(dma_busy), 32'(e_busy));
    chk("dma_valid", 32'(dma_valid), 32'(e_valid));
    chk("dma_done", 32'(dma_done), 32'(e_done));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    if (e_valid || reset) begin
      chk("dma_data", 32'(dma_data), 32'(e_data));
      chk("dma_idx", 32'(dma_idx), 32'(e_idx));
    end
  end

  // Transfer observation for the directed checks.
  int          valid_cnt = 0;
  int          done_cnt = 0;
  logic [7:0]  first_data = 8'h00;
  logic [7:0]  last_idx = 8'h00;
  logic [15:0] last_addr = 16'h0000;

  always @(negedge clk) begin
    if (dma_valid) begin
      if (valid_cnt == 0) first_data = dma_data;
      last_idx  = dma_idx;
      valid_cnt = valid_cnt + 1;
    end
    if (dma_done) done_cnt = done_cnt + 1;
    if (!halt_b) last_addr = mem_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    valid_cnt = 0;
    done_cnt  = 0;
  endtask

  task automatic req(input logic [15:0] base, input logic [7:0] len);
    dma_base = base;
    dma_len  = len;
    dma_req  = 1'b1;
    tick();
    dma_req  = 1'b0;
  endtask

  // Advance until dma_done is visible (inside the release cycle) or the budget runs out.
  task automatic wait_done(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      tick();
      if (dma_done) break;
    end
    if (i == budget) chk({name, "_timeout"}, 32'(0), 32'(1));
  endtask

  task automatic run_xfer(input logic [15:0] base, input logic [7:0] len, input string name,
                          input int exp_cnt, input logic [7:0] exp_first,
                          input logic [15:0] exp_last_addr, input logic [7:0] exp_last_idx);
    clear_mon();
    req(base, len);
    wait_done(exp_cnt + 20, name);
    tick();
    chk({name, "_valid_cnt"}, 32'(valid_cnt), 32'(exp_cnt));
    chk({name, "_first_data"}, 32'(first_data), 32'(exp_first));
    chk({name, "_last_addr"}, 32'(last_addr), 32'(exp_last_addr));
    chk({name, "_last_idx"}, 32'(last_idx), 32'(exp_last_idx));
    chk({name, "_done_cnt"}, 32'(done_cnt), 32'(1));
    chk({name, "_busy_after"}, 32'(dma_busy), 32'(0));
  endtask

  initial begin
    cpu_ab = 16'h1234;
    cpu_we = 1'b1;
    cpu_do = 8'h5A;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
    chk("idle_mem_addr", 32'(mem_addr), 32'h1234);
    chk("idle_mem_we", 32'(mem_we), 32'(1));
    chk("idle_mem_wdata", 32'(mem_wdata), 32'h5A);
    chk("idle_halt_b", 32'(halt_b), 32'(1));
    chk("idle_busy", 32'(dma_busy), 32'(0));
    chk("idle_dma_data", 32'(dma_data), 32'(0));

    // Halt timing: halt_b low in the two cycles after the accepting edge.
    clear_mon();
    req(16'h2000, 8'd4);
    chk("halt_c1", 32'(halt_b), 32'(0));
    chk("addr_c1_cpu", 32'(mem_addr), 32'h1234);
    tick();
    chk("halt_c2", 32'(halt_b), 32'(0));
    tick();
    chk("first_dma_addr", 32'(mem_addr), 32'h2000);
    chk("first_dma_we", 32'(mem_we), 32'(0));
    wait_done(30, "t1");
    chk("t1_done_halt_b", 32'(halt_b), 32'(1));
    tick();
    chk("t1_valid_cnt", 32'(valid_cnt), 32'(4));
    chk("t1_first_data", 32'(first_data), 32'h00);
    chk("t1_last_idx", 32'(last_idx), 32'(3));
    chk("t1_last_addr", 32'(last_addr), 32'h2003);
    chk("t1_done_cnt", 32'(done_cnt), 32'(1));

    run_xfer(16'hFFFE, 8'd3, "wrap", 3, 8'hFE, 16'h0000, 8'd2);
    run_xfer(16'h4000, 8'd0, "len256", 256, 8'h00, 16'h40FF, 8'd255);

    // Requests during XFER and in the release cycle are ignored.
    clear_mon();
    req(16'h1000, 8'd6);
    repeat (3) tick();
    req(16'h5555, 8'd2);
    wait_done(30, "ign");
    dma_base = 16'h7777;
    dma_len  = 8'd2;
    dma_req  = 1'b1;
    tick();
    dma_req  = 1'b0;
    repeat (10) tick();
    chk("ign_valid_cnt", 32'(valid_cnt), 32'(6));
    chk("ign_done_cnt", 32'(done_cnt), 32'(1));
    chk("ign_last_addr", 32'(last_addr), 32'h1005);
    chk("ign_busy", 32'(dma_busy), 32'(0));

    // Asynchronous reset in the middle of an 8-byte transfer.
    clear_mon();
    cpu_ab = 16'hBEEF;
    req(16'h3000, 8'd8);
    for (int i = 0; i < 30 && valid_cnt < 3; i++) tick();
    chk("rst_pre_cnt", 32'(valid_cnt), 32'(3));
    #2;
    reset = 1'b1;
    #1;
    chk("rst_halt_b", 32'(halt_b), 32'(1));
    chk("rst_mem_addr", 32'(mem_addr), 32'hBEEF);
    chk("rst_busy", 32'(dma_busy), 32'(0));
    chk("rst_valid", 32'(dma_valid), 32'(0));
    chk("rst_data", 32'(dma_data), 32'(0));
    tick();
    reset = 1'b0;
    repeat (12) tick();
    chk("rst_post_cnt", 32'(valid_cnt), 32'(3));
    chk("rst_post_done", 32'(done_cnt), 32'(0));

    run_xfer(16'h6000, 8'd2, "after_rst", 2, 8'h00, 16'h6001, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
